// File: rtl/input_conditioner.sv
// input_conditioner
// Turns asynchronous board switch/button levels into clean, synchronized
// per-channel levels, plus one-cycle rise/fall pulses on every accepted
// change. Each channel is synchronized through two flops and then debounced:
// a new level is only accepted once the synchronized input has disagreed
// with the current level for DB_CYCLES consecutive cycles.

module input_conditioner #(
    parameter int WIDTH     = 3,
    parameter int DB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             R,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Counter is sized to hold DB_CYCLES, but it never goes past
    // DB_CYCLES-1 because reaching that value on a mismatch accepts the
    // new level and clears the count instead of incrementing.
    localparam int             CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [CW-1:0]    r_cnt [WIDTH];

    logic [WIDTH-1:0] w_mismatch;
    logic [WIDTH-1:0] w_accept;

    // Two-flop synchronizer on every raw input bit before any other use.
    always_ff @(posedge clk) begin
        if (R) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw_raw;
            r_s2 <= r_s1;
        end
    end

    // A channel accepts its new level on the edge where it has already
    // seen DB_CYCLES-1 mismatching cycles and is still mismatching.
    always_comb begin
        w_mismatch = r_s2 ^ r_level;
        w_accept   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = w_mismatch[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    // Per-channel debounce counters, accepted levels and edge pulses.
    always_ff @(posedge clk) begin
        if (R) begin
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_rise[i] <= 1'b0;
                r_fall[i] <= 1'b0;
                if (!w_mismatch[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_level[i] <= r_s2[i];
                    r_rise[i]  <= r_s2[i];
                    r_fall[i]  <= ~r_s2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
// Directed bench for input_conditioner with DB_CYCLES=4, WIDTH=3. A
// history-based reference model predicts level/rise/fall every cycle, and
// hand-computed checkpoints pin the expected latency and pulse counts.

module tb_input_conditioner;

    localparam int WIDTH = 3;
    localparam int DB    = 4;

    logic             clk;
    logic             R;
    logic [WIDTH-1:0] swRaw;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    int checks;
    int errors;

    input_conditioner #(
        .WIDTH    (WIDTH),
        .DB_CYCLES(DB)
    ) dut (
        .clk   (clk),
        .R     (R),
        .sw_raw(swRaw),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state, updated once per rising edge.
    logic [WIDTH-1:0] mS1, mS2, mLevel, mRise, mFall;
    logic [DB-1:0]    mHist [WIDTH];
    int               mSince [WIDTH];
    bit               modelValid = 1'b0;

    // Model: a channel flips its level when the last DB synchronized samples
    // all disagree with it and at least DB edges have passed since the last
    // flip or reset.
    always @(posedge clk) begin
        if (R) begin
            mS1 = '0; mS2 = '0; mLevel = '0; mRise = '0; mFall = '0;
            for (int i = 0; i < WIDTH; i++) begin
                mHist[i]  = '0;
                mSince[i] = 0;
            end
            modelValid = 1'b1;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                mHist[i]  = {mHist[i][DB-2:0], mS2[i]};
                mSince[i] = (mSince[i] < 1000) ? mSince[i] + 1 : mSince[i];
                mRise[i]  = 1'b0;
                mFall[i]  = 1'b0;
                if (mSince[i] >= DB && mHist[i] == {DB{~mLevel[i]}}) begin
                    mLevel[i] = ~mLevel[i];
                    mRise[i]  = mLevel[i];
                    mFall[i]  = ~mLevel[i];
                    mSince[i] = 0;
                end
            end
            mS2 = mS1;
            mS1 = swRaw;
        end
    end

    int riseCount [WIDTH];
    int fallCount [WIDTH];

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
        end
    endtask

    // Every falling edge: compare against the model and tally DUT pulses.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("model_level", level, mLevel);
            checkOutput("model_rise", rise, mRise);
            checkOutput("model_fall", fall, mFall);
            checkOutput("rise_and_fall", rise & fall, '0);
            for (int i = 0; i < WIDTH; i++) begin
                if (rise[i] === 1'b1) riseCount[i]++;
                if (fall[i] === 1'b1) fallCount[i]++;
            end
        end
    end

    // Drive a new raw value just after a rising edge, then wait n falling edges.
    // The first falling edge waited on comes before the edge that samples it.
    task automatic applyStimulus(input logic [WIDTH-1:0] v, input int n);
        @(posedge clk);
        #2 swRaw = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic clearCounts();
        for (int i = 0; i < WIDTH; i++) begin
            riseCount[i] = 0;
            fallCount[i] = 0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clearCounts();
        R     = 1'b1;
        swRaw = 3'b111;

        // Reset held two edges with all switches high.
        @(negedge clk);
        checkOutput("reset_level", level, 3'b000);
        checkOutput("reset_rise", rise, 3'b000);
        @(posedge clk);
        #2 R = 1'b0;
        @(negedge clk);
        checkOutput("reset_level2", level, 3'b000);
        repeat (5) @(negedge clk);
        checkOutput("post_reset_level_k4", level, 3'b000);
        @(negedge clk);
        checkOutput("post_reset_level_k5", level, 3'b111);
        checkOutput("post_reset_rise", rise, 3'b111);
        @(negedge clk);
        checkOutput("post_reset_rise_gone", rise, 3'b000);
        checkOutput("post_reset_level_hold", level, 3'b111);

        applyStimulus(3'b000, 10);
        checkOutput("all_released", level, 3'b000);

        // Glitch on channel 0 lasting 3 cycles.
        clearCounts();
        applyStimulus(3'b001, 3);
        applyStimulus(3'b000, 10);
        checkOutput("glitch_level", level, 3'b000);
        checkOutput("glitch_pulses", 3'(riseCount[0] + fallCount[0]), 3'd0);

        // Clean press and release on channel 1.
        clearCounts();
        applyStimulus(3'b010, 6);
        checkOutput("press_level_k4", level, 3'b000);
        @(negedge clk);
        checkOutput("press_level_k5", level, 3'b010);
        checkOutput("press_rise", rise, 3'b010);
        repeat (3) @(negedge clk);
        applyStimulus(3'b000, 6);
        checkOutput("release_level_k4", level, 3'b010);
        @(negedge clk);
        checkOutput("release_level_k5", level, 3'b000);
        checkOutput("release_fall", fall, 3'b010);
        repeat (4) @(negedge clk);
        checkOutput("press_rise_count", 3'(riseCount[1]), 3'd1);
        checkOutput("press_fall_count", 3'(fallCount[1]), 3'd1);

        // Bounce on channel 2, then settle high.
        clearCounts();
        for (int i = 0; i < 6; i++) begin
            applyStimulus((i % 2 == 0) ? 3'b100 : 3'b000, 2);
        end
        checkOutput("bounce_level", level, 3'b000);
        applyStimulus(3'b100, 6);
        checkOutput("bounce_level_k4", level, 3'b000);
        @(negedge clk);
        checkOutput("bounce_level_k5", level, 3'b100);
        repeat (4) @(negedge clk);
        checkOutput("bounce_rise_count", 3'(riseCount[2]), 3'd1);
        checkOutput("bounce_fall_count", 3'(fallCount[2]), 3'd0);

        // Simultaneous acceptance on channels 0 and 2.
        applyStimulus(3'b000, 10);
        clearCounts();
        applyStimulus(3'b101, 6);
        checkOutput("simul_level_k4", level, 3'b000);
        @(negedge clk);
        checkOutput("simul_rise", rise, 3'b101);
        checkOutput("simul_level", level, 3'b101);
        @(negedge clk);
        checkOutput("simul_rise_gone", rise, 3'b000);
        checkOutput("simul_level_hold", level, 3'b101);

        // Reset pulse mid-count on channel 0 aborts the change.
        applyStimulus(3'b000, 10);
        clearCounts();
        applyStimulus(3'b001, 5);
        @(posedge clk);
        #2 R = 1'b1;
        @(posedge clk);
        #2 R = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("midreset_level_k4", level, 3'b000);
        checkOutput("midreset_no_pulse", 3'(riseCount[0]), 3'd0);
        @(negedge clk);
        checkOutput("midreset_level_k5", level, 3'b001);
        checkOutput("midreset_rise", rise, 3'b001);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected end earlier", $time);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
